mc_ctrl: RTL
============

// Module: mc_ctrl
// PURPOSE
// Multicycle control FSM that drives the ALU's ALUOp/zero interface from the opposite end. Decodes
// opcode/funct from the IR, sequences FETCH..WRITEBACK per instruction and emits datapath strobes and
// mux selects. Consumes ALU zero for beq; stalls on a memory ready handshake.
// PARAMETERS
// RET_W  32  width of retired-instruction counter ret_cnt
// PORTS
// clk        in   1       rising-edge clock
// reset      in   1       synchronous, active-high reset
// op         in   6       IR[31:26]
// funct      in   6       IR[5:0]
// zero       in   1       ALU zero flag
// mem_ready  in   1       memory completes current mem_req this cycle
// mem_req    out  1       memory access request (fetch/lw/sw)
// mem_we     out  1       memory write (sw)
// ir_we      out  1       IR load
// pc_we      out  1       PC load
// reg_we     out  1       register file write
// reg_dst    out  1       0=rt, 1=rd
// mem_to_reg out  1       0=ALUOut, 1=MDR
// pc_src     out  2       0=ALU result, 1=ALUOut, 2=jump target
// alu_src_a  out  2       0=PC, 1=rs, 2=rt, 3=zext imm
// alu_src_b  out  3       0=rt, 1=4, 2=sext imm, 3=zext imm, 4=sext imm<<2, 5=zext shamt, 6=16
// alu_op     out  3       0=AND, 1=OR, 2=ADD, 3=SUB, 4=SHL (A<<B)
// illegal    out  1       sticky illegal-instruction flag (MC_ILLEGAL_TRAP_EN only; else tied 0)
// ret_cnt    out  RET_W   retired-instruction counter
// BEHAVIOUR
// - Reset: state<=FETCH, ret_cnt<=0, illegal<=0. While reset=1 all strobes (mem_req, mem_we, ir_we,
//   pc_we, reg_we) are 0; selects are 0; reset mid-instruction abandons it, no write occurs.
// - Outputs are Moore decode of state (plus mem_ready/zero gating below); unlisted signals are 0.
// - Supported: R(op=0): addu 21h->ADD, subu 23h->SUB, and 24h->AND, or 25h->OR, sll 00h->SHL;
//   ori 0Dh, lui 0Fh, lw 23h, sw 2Bh, beq 04h, j 02h.
// - FETCH: mem_req=1, src_a=0, src_b=1, op=ADD, pc_src=0; ir_we=pc_we=mem_ready; stay until
//   mem_ready, then ->DECODE. No strobe repeats while stalled.
// - DECODE: src_a=0, src_b=4, op=ADD (branch target into ALUOut); next by op:
//   R->EXEC_R, ori/lui->EXEC_I, lw/sw->MEM_ADDR, beq->BRANCH, j->JUMP, else unsupported.
// - EXEC_R: src_a=1 (sll: 2), src_b=0 (sll: 5), alu_op per funct -> WB_R.
// - EXEC_I: ori: src_a=1,src_b=3,OR; lui: src_a=3,src_b=6,SHL -> WB_I.
// - WB_R: reg_we=1, reg_dst=1; WB_I: reg_we=1, reg_dst=0; both ->FETCH, retire.
// - MEM_ADDR: src_a=1, src_b=2, ADD -> MEM_RD (lw) / MEM_WR (sw).
// - MEM_RD: mem_req=1; wait mem_ready -> MEM_WB. MEM_WB: reg_we=1, mem_to_reg=1 ->FETCH, retire.
// - MEM_WR: mem_req=mem_we=1, held until mem_ready ->FETCH, retire on ready cycle.
// - BRANCH: src_a=1, src_b=0, SUB, pc_src=1, pc_we=zero ->FETCH, retire (taken or not).
// - JUMP: pc_src=2, pc_we=1 ->FETCH, retire.
// - Latency with mem_ready=1 throughout: R/ori/lui 4, lw 5, sw 4, beq 3, j 3 cycles; each memory
//   stall cycle adds 1.
// - ret_cnt +1 in the final cycle of each instruction; wraps 2^RET_W-1 -> 0.
// - Unsupported op or R funct: see CONFIGURATION. Never any reg/mem write for it.
// CONFIGURATION
// MC_ILLEGAL_TRAP_EN defined: unsupported instr -> TRAP state; illegal<=1; TRAP holds forever
//   (all strobes 0, no fetch, ret_cnt frozen) until reset.
// Not defined: unsupported instr is a NOP: DECODE ->FETCH, retires (ret_cnt+1); illegal=0 always.
// TESTING
// 1. reset=1 3 cycles mid-lw -> strobes 0 during reset; FETCH with mem_req=1 next cycle; ret_cnt=0.
// 2. addu (op=0,funct=21h), mem_ready=1 -> alu_op=2 in EXEC_R, reg_we=1,reg_dst=1 in cycle 4; ret_cnt=1.
// 3. lw with mem_ready=0 for 2 cycles in MEM_RD -> mem_req held, reg_we only in MEM_WB, total 7 cycles.
// 4. beq with zero=1 -> pc_we=1,pc_src=1,alu_op=3 in cycle 3; repeat zero=0 -> pc_we=0, still retires.
// 5. lui -> alu_src_a=3, alu_src_b=6, alu_op=4; sll -> src_a=2, src_b=5, alu_op=4.
// 6. op=3Fh -> with MC_ILLEGAL_TRAP_EN illegal=1, no mem_req thereafter; without, FETCH next, ret_cnt+1.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multicycle control FSM: decodes op/funct, sequences each instruction and drives datapath strobes/selects.
// Optional MC_ILLEGAL_TRAP_EN: unsupported instructions trap (sticky illegal flag) instead of retiring as NOPs.
module mc_ctrl #(
    parameter int RET_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic             reg_we,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_src_a,
    output logic [2:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             illegal,
    output logic [RET_W-1:0] ret_cnt
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_R, S_WB_I, S_MEM_ADDR,
        S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_TRAP
    } state_t;

    localparam logic [5:0] OP_R = 6'h00, OP_ORI = 6'h0D, OP_LUI = 6'h0F, OP_LW = 6'h23,
                           OP_SW = 6'h2B, OP_BEQ = 6'h04, OP_J = 6'h02;
    localparam logic [5:0] FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND = 6'h24,
                           FN_OR = 6'h25, FN_SLL = 6'h00;
    localparam logic [2:0] ALU_AND = 3'd0, ALU_OR = 3'd1, ALU_ADD = 3'd2,
                           ALU_SUB = 3'd3, ALU_SHL = 3'd4;

    state_t     state, next_state;
    logic       r_ok, unsupported, is_sll, retire;
    logic [2:0] alu_r;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        r_ok  = 1'b0;
        alu_r = ALU_ADD;
        unique case (funct)
            FN_ADDU: begin r_ok = 1'b1; alu_r = ALU_ADD; end
            FN_SUBU: begin r_ok = 1'b1; alu_r = ALU_SUB; end
            FN_AND:  begin r_ok = 1'b1; alu_r = ALU_AND; end
            FN_OR:   begin r_ok = 1'b1; alu_r = ALU_OR;  end
            FN_SLL:  begin r_ok = 1'b1; alu_r = ALU_SHL; end
            default: ;
        endcase
        is_sll = (funct == FN_SLL);
        unique case (op)
            OP_R:                                    unsupported = !r_ok;
            OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J: unsupported = 1'b0;
            default:                                 unsupported = 1'b1;
        endcase
    end

    // NOTE: state and counters use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_FETCH:    if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                if (unsupported) begin
`ifdef MC_ILLEGAL_TRAP_EN
                    next_state = S_TRAP;
`else
                    next_state = S_FETCH;
`endif
                end else begin
                    unique case (op)
                        OP_R:           next_state = S_EXEC_R;
                        OP_ORI, OP_LUI: next_state = S_EXEC_I;
                        OP_LW, OP_SW:   next_state = S_MEM_ADDR;
                        OP_BEQ:         next_state = S_BRANCH;
                        default:        next_state = S_JUMP;
                    endcase
                end
            end
            S_EXEC_R:   next_state = S_WB_R;
            S_EXEC_I:   next_state = S_WB_I;
            S_MEM_ADDR: next_state = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) next_state = S_MEM_WB;
            S_MEM_WR:   if (mem_ready) next_state = S_FETCH;
            S_TRAP:     next_state = S_TRAP;
            default:    next_state = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        pc_src     = 2'd0;
        alu_src_a  = 2'd0;
        alu_src_b  = 3'd0;
        alu_op     = ALU_AND;
        // Reset masks the decode so a half-finished instruction can never write.
        if (!reset) begin
            unique case (state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    ir_we     = mem_ready;
                    pc_we     = mem_ready;
                    alu_src_b = 3'd1;
                    alu_op    = ALU_ADD;
                end
                S_DECODE: begin
                    alu_src_b = 3'd4;
                    alu_op    = ALU_ADD;
                end
                S_EXEC_R: begin
                    alu_src_a = is_sll ? 2'd2 : 2'd1;
                    alu_src_b = is_sll ? 3'd5 : 3'd0;
                    alu_op    = alu_r;
                end
                S_EXEC_I: begin
                    alu_src_a = (op == OP_LUI) ? 2'd3 : 2'd1;
                    alu_src_b = (op == OP_LUI) ? 3'd6 : 3'd3;
                    alu_op    = (op == OP_LUI) ? ALU_SHL : ALU_OR;
                end
                S_WB_R: begin
                    reg_we  = 1'b1;
                    reg_dst = 1'b1;
                end
                S_WB_I:     reg_we = 1'b1;
                S_MEM_ADDR: begin
                    alu_src_a = 2'd1;
                    alu_src_b = 3'd2;
                    alu_op    = ALU_ADD;
                end
                S_MEM_RD:   mem_req = 1'b1;
                S_MEM_WB: begin
                    reg_we     = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 2'd1;
                    alu_op    = ALU_SUB;
                    pc_src    = 2'd1;
                    pc_we     = zero;
                end
                S_JUMP: begin
                    pc_src = 2'd2;
                    pc_we  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        unique case (state)
            S_WB_R, S_WB_I, S_MEM_WB, S_BRANCH, S_JUMP: retire = 1'b1;
            S_MEM_WR:                                  retire = mem_ready;
`ifdef MC_ILLEGAL_TRAP_EN
            S_DECODE:                                  retire = 1'b0;
`else
            S_DECODE:                                  retire = unsupported;
`endif
            default:                                   retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)       ret_cnt <= '0;
        else if (retire) ret_cnt <= ret_cnt + RET_W'(1);
    end

`ifdef MC_ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge clk) begin
        if (reset)                                 illegal_q <= 1'b0;
        else if (state == S_DECODE && unsupported) illegal_q <= 1'b1;
    end
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

endmodule
